prbs8_checker: RTL and testbench

- Serial receive-side checker for the x^8+x^6+x^3+x^2+1 pseudo-random sequence (taps 8,6,3,2) that our 8-bit LFSR generator produces.
- Self-synchronises to the incoming bit stream, declares lock, then flags and counts bit errors.
- Sits at the far end of a link or loopback and gives the bench and the design a pass/fail and error-rate indication.

---
 rtl/prbs8_checker_if.sv | 25 ++
 rtl/prbs8_checker.sv | 154 +++++++++++++++
 tb/tb_prbs8_checker.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prbs8_checker_if.sv
// prbs8_checker_if: stream/status bundle between a PRBS8 source and the checker.
// bit_cnt exists only when PRBS8_CHK_BITCNT_EN is defined.
`default_nettype none

interface prbs8_checker_if #(
  parameter int CNT_W = 16
);
  logic             ena;
  logic             din;
  logic             clr;
  logic             lock;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
`ifdef PRBS8_CHK_BITCNT_EN
  logic [31:0]      bit_cnt;

  modport master (output ena, din, clr, input lock, err, err_cnt, bit_cnt);
  modport slave  (input ena, din, clr, output lock, err, err_cnt, bit_cnt);
`else
  modport master (output ena, din, clr, input lock, err, err_cnt);
  modport slave  (input ena, din, clr, output lock, err, err_cnt);
`endif
endinterface

`default_nettype wire

// File: rtl/prbs8_checker.sv
// ---------------------------------------------------------------------------
// prbs8_checker: self-synchronising checker for x^8+x^6+x^3+x^2+1 serial PRBS,
// with lock detect and error counting. Macro PRBS8_CHK_BITCNT_EN adds bit_cnt.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prbs8_checker #(
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_ERR = 4,
  parameter int WIN        = 32,
  parameter int CNT_W      = 16
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  prbs8_checker_if.slave bus
);

  localparam int WW = $clog2(WIN + 1);

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [8:1]       hist, hist_nx;
  logic [2:0]       fill, fill_nx;
  logic [7:0]       match, match_nx;
  logic [WW-1:0]    win_cnt, win_nx, bad, bad_nx;
  logic             err_q, err_nx;
  logic [CNT_W-1:0] err_cnt, err_cnt_nx;

  logic             pred;
  logic             miss;
  logic [7:0]       match_inc;
  logic [WW-1:0]    win_inc;
  logic [WW-1:0]    bad_inc;
  logic [CNT_W-1:0] err_base;

  assign pred      = hist[8] ^ hist[6] ^ hist[3] ^ hist[2];
  assign miss      = bus.din != pred;
  assign match_inc = match + 8'd1;
  assign win_inc   = win_cnt + WW'(1);
  assign bad_inc   = bad + WW'(miss);
  // Clear takes effect before any error counted on the same edge.
  assign err_base  = bus.clr ? '0 : err_cnt;

  always_comb begin
    state_nx   = state;
    hist_nx    = hist;
    fill_nx    = fill;
    match_nx   = match;
    win_nx     = win_cnt;
    bad_nx     = bad;
    err_nx     = 1'b0;
    err_cnt_nx = err_base;
    if (bus.ena) begin
      case (state)
        ACQ: begin
          hist_nx = {hist[7:1], bus.din};
          fill_nx = fill + 3'd1;
          if (fill == 3'd7) begin
            state_nx = VERIFY;
            match_nx = '0;
          end
        end
        VERIFY: begin
          hist_nx = {hist[7:1], bus.din};
          if (miss || hist == 8'h00) begin
            match_nx = '0;
          end else begin
            match_nx = match_inc;
            if (match_inc == 8'(LOCK_CNT)) begin
              state_nx = LOCKED;
              win_nx   = '0;
              bad_nx   = '0;
            end
          end
        end
        LOCKED: begin
          // History regenerates from the prediction so line errors cannot corrupt it.
          hist_nx = {hist[7:1], pred};
          if (miss) begin
            err_nx = 1'b1;
            if (err_base != '1) err_cnt_nx = err_base + CNT_W'(1);
          end
          if (bad_inc == WW'(UNLOCK_ERR)) begin
            state_nx = ACQ;
            fill_nx  = '0;
            win_nx   = '0;
            bad_nx   = '0;
          end else if (win_inc == WW'(WIN)) begin
            win_nx = '0;
            bad_nx = '0;
          end else begin
            win_nx = win_inc;
            bad_nx = bad_inc;
          end
        end
        default: state_nx = ACQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ACQ;
      hist    <= '0;
      fill    <= '0;
      match   <= '0;
      win_cnt <= '0;
      bad     <= '0;
      err_q   <= 1'b0;
      err_cnt <= '0;
    end else begin
      state   <= state_nx;
      hist    <= hist_nx;
      fill    <= fill_nx;
      match   <= match_nx;
      win_cnt <= win_nx;
      bad     <= bad_nx;
      err_q   <= err_nx;
      err_cnt <= err_cnt_nx;
    end
  end

  assign bus.lock    = (state == LOCKED);
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt;

`ifdef PRBS8_CHK_BITCNT_EN
  logic [31:0] bit_cnt;
  logic [31:0] bit_base;

  assign bit_base = bus.clr ? 32'd0 : bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (bus.ena && state == LOCKED && bit_base != 32'hFFFF_FFFF) begin
      bit_cnt <= bit_base + 32'd1;
    end else begin
      bit_cnt <= bit_base;
    end
  end

  assign bus.bit_cnt = bit_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_prbs8_checker.sv
// tb_prbs8_checker: randomized stimulus against a queue-based reference model of
// the PRBS8 checker's acquire/verify/lock rules.
`default_nettype none

module tb_prbs8_checker;

  localparam int     LOCK_CNT   = 16;
  localparam int     UNLOCK_ERR = 4;
  localparam int     WIN        = 32;
  localparam int     CNT_W      = 16;
  localparam longint CNT_MAX    = (longint'(1) << CNT_W) - 1;
  localparam longint BIT_MAX    = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  prbs8_checker_if #(.CNT_W(CNT_W)) bus ();

  prbs8_checker #(
    .LOCK_CNT  (LOCK_CNT),
    .UNLOCK_ERR(UNLOCK_ERR),
    .WIN       (WIN),
    .CNT_W     (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Generator: reference bit sequence b[n] = b[n-8]^b[n-6]^b[n-3]^b[n-2], seed first.
  bit       gbits[$];
  bit [7:0] gseed = 8'h01;

  function automatic void gen_reset();
    gbits.delete();
  endfunction

  function automatic bit gen_next();
    int n = gbits.size();
    bit b;
    if (n < 8) b = gseed[n];
    else       b = gbits[n-8] ^ gbits[n-6] ^ gbits[n-3] ^ gbits[n-2];
    gbits.push_back(b);
    return b;
  endfunction

  // Reference model: mh[k-1] is the bit received k steps ago.
  bit     mh[$];
  int     m_state;   // 0 acquire, 1 verify, 2 locked
  int     m_fill, m_match, m_win, m_bad;
  longint m_cnt, m_bits;
  bit     m_err, m_lock;

  function automatic void model_reset();
    mh.delete();
    for (int i = 0; i < 8; i++) mh.push_back(1'b0);
    m_state = 0; m_fill = 0; m_match = 0; m_win = 0; m_bad = 0;
    m_cnt = 0; m_bits = 0; m_err = 1'b0; m_lock = 1'b0;
  endfunction

  function automatic void model_edge(input bit e, input bit d, input bit c);
    bit p;
    bit nz;
    m_err = 1'b0;
    if (c) begin m_cnt = 0; m_bits = 0; end
    if (e) begin
      p  = mh[7] ^ mh[5] ^ mh[2] ^ mh[1];
      nz = 1'b0;
      foreach (mh[i]) nz |= mh[i];
      if (m_state == 0) begin
        mh.push_front(d); void'(mh.pop_back());
        m_fill++;
        if (m_fill == 8) begin m_state = 1; m_fill = 0; m_match = 0; end
      end else if (m_state == 1) begin
        mh.push_front(d); void'(mh.pop_back());
        if (d != p || !nz) m_match = 0;
        else m_match++;
        if (m_match == LOCK_CNT) begin m_state = 2; m_win = 0; m_bad = 0; end
      end else begin
        if (m_bits < BIT_MAX) m_bits++;
        mh.push_front(p); void'(mh.pop_back());
        if (d != p) begin
          m_err = 1'b1;
          if (m_cnt < CNT_MAX) m_cnt++;
          m_bad++;
        end
        m_win++;
        if (m_bad == UNLOCK_ERR) begin
          m_state = 0; m_fill = 0; m_win = 0; m_bad = 0;
        end else if (m_win == WIN) begin
          m_win = 0; m_bad = 0;
        end
      end
    end
    m_lock = (m_state == 2);
  endfunction

  task automatic step(input bit e, input bit d, input bit c);
    @(negedge clk);
    bus.ena = e; bus.din = d; bus.clr = c;
    @(posedge clk);
    model_edge(e, d, c);
    #1;
  endtask

  task automatic send(input bit e, input bit flip, input bit c);
    bit d;
    if (e) d = gen_next() ^ flip;
    else   d = 1'($urandom);
    step(e, d, c);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.ena = 1'b0; bus.din = 1'b0; bus.clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    gen_reset();
  endtask

  task automatic test_reset();
    bus.ena = 1'b1; bus.din = 1'b1; bus.clr = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    n_checks++;
    if (bus.lock !== 1'b0 || bus.err !== 1'b0 || bus.err_cnt !== '0)
      $display("FAIL reset_async: lock/err/cnt=%b/%b/%0d want 0/0/0", bus.lock, bus.err, bus.err_cnt);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.lock !== 1'b0 || bus.err !== 1'b0 || bus.err_cnt !== '0)
      $display("FAIL reset_held: lock/err/cnt=%b/%b/%0d want 0/0/0", bus.lock, bus.err, bus.err_cnt);
    else n_pass++;
`ifdef PRBS8_CHK_BITCNT_EN
    n_checks++;
    if (bus.bit_cnt !== 32'd0) $display("FAIL reset_bitcnt: got %0d want 0", bus.bit_cnt);
    else n_pass++;
`endif
    @(negedge clk);
    bus.ena = 1'b0;
    rst_n = 1'b1;
    model_reset();
    gen_reset();
  endtask

  task automatic test_lock_clean();
    for (int i = 1; i <= 1000; i++) begin
      send(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (bus.lock !== m_lock || bus.err !== m_err || bus.err_cnt !== CNT_W'(m_cnt))
        $display("FAIL clean_stream edge %0d: lock/err/cnt=%b/%b/%0d want %b/%b/%0d",
                 i, bus.lock, bus.err, bus.err_cnt, m_lock, m_err, m_cnt);
      else n_pass++;
      if (i == 23 || i == 24) begin
        n_checks++;
        if (bus.lock !== (i == 24))
          $display("FAIL lock_edge24 edge %0d: lock=%b want %b", i, bus.lock, (i == 24));
        else n_pass++;
      end
    end
    n_checks++;
    if (bus.err_cnt !== '0) $display("FAIL clean_errcnt: got %0d want 0", bus.err_cnt);
    else n_pass++;
  endtask

  task automatic test_single_errors();
    int pulses = 0;
    for (int i = 1; i <= 400; i++) begin
      send(1'b1, (i == 100 || i == 300), 1'b0);
      if (bus.err === 1'b1) pulses++;
      n_checks++;
      if (bus.lock !== m_lock || bus.err !== m_err || bus.err_cnt !== CNT_W'(m_cnt))
        $display("FAIL single_err bit %0d: lock/err/cnt=%b/%b/%0d want %b/%b/%0d",
                 i, bus.lock, bus.err, bus.err_cnt, m_lock, m_err, m_cnt);
      else n_pass++;
    end
    n_checks++;
    if (pulses != 2 || bus.err_cnt !== 16'd2 || bus.lock !== 1'b1)
      $display("FAIL single_err_summary: pulses/cnt/lock=%0d/%0d/%b want 2/2/1", pulses, bus.err_cnt, bus.lock);
    else n_pass++;
  endtask

  task automatic test_unlock();
    int relock = -1;
    for (int i = 0; i < 40 && m_win != 0; i++) send(1'b1, 1'b0, 1'b0);
    for (int k = 0; k <= 12; k++) begin
      send(1'b1, (k % 4 == 0), 1'b0);
      n_checks++;
      if (bus.lock !== m_lock || bus.err !== m_err || bus.err_cnt !== CNT_W'(m_cnt))
        $display("FAIL unlock bit %0d: lock/err/cnt=%b/%b/%0d want %b/%b/%0d",
                 k, bus.lock, bus.err, bus.err_cnt, m_lock, m_err, m_cnt);
      else n_pass++;
    end
    n_checks++;
    if (bus.lock !== 1'b0 || bus.err_cnt !== 16'd6)
      $display("FAIL unlock_4th: lock/cnt=%b/%0d want 0/6", bus.lock, bus.err_cnt);
    else n_pass++;
    for (int i = 1; i <= 100 && relock < 0; i++) begin
      send(1'b1, 1'b0, 1'b0);
      if (bus.lock === 1'b1) relock = i;
    end
    n_checks++;
    if (relock != 24 || bus.err_cnt !== 16'd6)
      $display("FAIL relock: bits/cnt=%0d/%0d want 24/6", relock, bus.err_cnt);
    else n_pass++;
  endtask

  task automatic test_clr_with_error();
    repeat (200) send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b1);
    n_checks++;
    if (bus.err_cnt !== 16'd1 || bus.err !== 1'b1 || bus.lock !== 1'b1)
      $display("FAIL clr_with_err: cnt/err/lock=%0d/%b/%b want 1/1/1", bus.err_cnt, bus.err, bus.lock);
    else n_pass++;
`ifdef PRBS8_CHK_BITCNT_EN
    n_checks++;
    if (bus.bit_cnt !== 32'd1) $display("FAIL clr_bitcnt: got %0d want 1", bus.bit_cnt);
    else n_pass++;
`endif
    send(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_zero_stream();
    int seen = 0;
    apply_reset();
    for (int i = 1; i <= 500; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (bus.lock === 1'b1 || bus.err === 1'b1) seen++;
      n_checks++;
      if (bus.lock !== m_lock || bus.err !== m_err || bus.err_cnt !== CNT_W'(m_cnt))
        $display("FAIL zero_stream bit %0d: lock/err/cnt=%b/%b/%0d want %b/%b/%0d",
                 i, bus.lock, bus.err, bus.err_cnt, m_lock, m_err, m_cnt);
      else n_pass++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL zero_never_lock: lock/err high cycles=%0d want 0", seen);
    else n_pass++;
  endtask

  task automatic test_ena_toggle();
    int ena_edges = 0;
    int lock_clk  = -1;
    int lock_ena  = -1;
    apply_reset();
    for (int i = 1; i <= 70; i++) begin
      send(i % 2 == 1, 1'b0, 1'b0);
      if (i % 2 == 1) ena_edges++;
      if (bus.lock === 1'b1 && lock_clk < 0) begin lock_clk = i; lock_ena = ena_edges; end
      n_checks++;
      if (bus.lock !== m_lock || bus.err !== m_err || bus.err_cnt !== CNT_W'(m_cnt))
        $display("FAIL ena_toggle clk %0d: lock/err/cnt=%b/%b/%0d want %b/%b/%0d",
                 i, bus.lock, bus.err, bus.err_cnt, m_lock, m_err, m_cnt);
      else n_pass++;
    end
    n_checks++;
    if (lock_ena != 24 || lock_clk != 47)
      $display("FAIL ena_toggle_lock: ena_edges/clocks=%0d/%0d want 24/47", lock_ena, lock_clk);
    else n_pass++;
  endtask

  task automatic test_random();
    bit e, f, c;
    for (int i = 1; i <= 3000; i++) begin
      e = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 47) == 0);
      c = ($urandom_range(0, 199) == 0);
      send(e, f, c);
      n_checks++;
      if (bus.lock !== m_lock || bus.err !== m_err || bus.err_cnt !== CNT_W'(m_cnt))
        $display("FAIL random cyc %0d: lock/err/cnt=%b/%b/%0d want %b/%b/%0d",
                 i, bus.lock, bus.err, bus.err_cnt, m_lock, m_err, m_cnt);
      else n_pass++;
`ifdef PRBS8_CHK_BITCNT_EN
      n_checks++;
      if (bus.bit_cnt !== 32'(m_bits))
        $display("FAIL random_bitcnt cyc %0d: got %0d want %0d", i, bus.bit_cnt, m_bits);
      else n_pass++;
`endif
    end
  endtask

  task automatic test_reset_mid_lock();
    repeat (80) send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (bus.lock !== 1'b1 || bus.err !== 1'b1 || bus.err_cnt === '0)
      $display("FAIL pre_reset_state: lock/err/cnt=%b/%b/%0d want 1/1/nonzero", bus.lock, bus.err, bus.err_cnt);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.lock !== 1'b0 || bus.err !== 1'b0 || bus.err_cnt !== '0)
      $display("FAIL reset_mid_lock: lock/err/cnt=%b/%b/%0d want 0/0/0", bus.lock, bus.err, bus.err_cnt);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    gen_reset();
    for (int i = 1; i <= 30; i++) begin
      send(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (bus.lock !== m_lock || bus.err !== m_err || bus.err_cnt !== CNT_W'(m_cnt))
        $display("FAIL post_reset edge %0d: lock/err/cnt=%b/%b/%0d want %b/%b/%0d",
                 i, bus.lock, bus.err, bus.err_cnt, m_lock, m_err, m_cnt);
      else n_pass++;
    end
  endtask

  initial begin
    bus.ena = 1'b0; bus.din = 1'b0; bus.clr = 1'b0;
    model_reset();
    gen_reset();
    test_reset();
    test_lock_clean();
    test_single_errors();
    test_unlock();
    test_clr_with_error();
    test_zero_stream();
    test_ena_toggle();
    test_random();
    test_reset_mid_lock();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
